// File: rtl/cxl_retry_pkg.sv
// Shared definitions for the CXL link-layer retry path: LRSM state encoding
// and the default retry/timeout/reinit limits.
package cxl_retry_pkg;

    typedef enum logic [2:0] {
        LRSM_NORMAL     = 3'd0,
        LRSM_LLRREQ     = 3'd1,
        LRSM_LOCAL_IDLE = 3'd2,
        LRSM_PHY_REINIT = 3'd3,
        LRSM_ABORT      = 3'd4
    } lrsm_state_e;

    localparam int unsigned LRSM_TIMER_W = 12;

    localparam logic [4:0]              DEF_MAX_NUM_RETRY      = 5'd5;
    localparam logic [LRSM_TIMER_W-1:0] DEF_TIMEOUT_CYC        = 12'd1000;
    localparam logic [1:0]              DEF_MAX_NUM_PHY_REINIT = 2'd3;

endpackage

// File: rtl/lrsm_timeout_timer.sv
// Saturating up-counter used as the LOCAL_IDLE RETRY.Ack timeout.
// Clear has priority over enable; tc_o flags count == TERMINAL.
module lrsm_timeout_timer
    import cxl_retry_pkg::*;
#(
    parameter int unsigned    W        = LRSM_TIMER_W,
    parameter logic [W-1:0]   TERMINAL = DEF_TIMEOUT_CYC - 12'd1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/cxl_lrsm_ctrl.sv
// CXL Local Retry State Machine controller. PHY reinit escalation is built
// only when CXL_LRSM_PHY_REINIT_EN is defined; otherwise exhaustion aborts.
module cxl_lrsm_ctrl
    import cxl_retry_pkg::*;
#(
    parameter logic [4:0]  MAX_NUM_RETRY      = DEF_MAX_NUM_RETRY,
    parameter logic [11:0] TIMEOUT_CYC        = DEF_TIMEOUT_CYC,
    parameter logic [1:0]  MAX_NUM_PHY_REINIT = DEF_MAX_NUM_PHY_REINIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       crc_err_detected,
    input  logic       retryreq_ack,
    input  logic       retryack_rcvd,
    input  logic       retryack_empty_bit,
    input  logic       num_retry_matches,
    input  logic [4:0] retry_num_retry,
    input  logic       phy_reinit_done,
    output logic       send_retryreq,
    output logic       num_retry_inc_en,
    output logic       num_retry_reset,
    output logic       empty_bit_detected_reset,
    output logic       rx_discard,
    output logic       phy_reinit_req,
    output logic       link_abort,
    output logic [2:0] lrsm_state
);

    lrsm_state_e state_q;
    lrsm_state_e state_d;

    logic timer_clr;
    logic timer_en;
    logic timer_tc;
    logic retries_exhausted;
    logic ack_matched;

    assign retries_exhausted = (retry_num_retry >= MAX_NUM_RETRY);
    assign ack_matched       = retryack_rcvd && num_retry_matches;
    assign timer_en          = (state_q == LRSM_LOCAL_IDLE);

    lrsm_timeout_timer #(
        .W        (12),
        .TERMINAL (TIMEOUT_CYC - 12'd1)
    ) u_timer (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tc_o   (timer_tc)
    );

`ifdef CXL_LRSM_PHY_REINIT_EN
    logic [1:0] reinit_cnt_q;
    logic [1:0] reinit_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reinit_cnt_q <= '0;
        end else begin
            reinit_cnt_q <= reinit_cnt_d;
        end
    end

    assign phy_reinit_req = (state_q == LRSM_PHY_REINIT);
`else
    logic unused_phy_reinit;
    assign unused_phy_reinit = ^{phy_reinit_done, MAX_NUM_PHY_REINIT};
    assign phy_reinit_req    = 1'b0;
`endif

    // Pulses are decoded on the transition cycle so NUM_RETRY moves on the
    // same edge as the state register.
    always_comb begin
        state_d                  = state_q;
        timer_clr                = 1'b0;
        num_retry_inc_en         = 1'b0;
        num_retry_reset          = 1'b0;
        empty_bit_detected_reset = 1'b0;
`ifdef CXL_LRSM_PHY_REINIT_EN
        reinit_cnt_d             = reinit_cnt_q;
`endif
        case (state_q)
            LRSM_NORMAL: begin
                if (crc_err_detected) begin
                    state_d = LRSM_LLRREQ;
                end
            end
            LRSM_LLRREQ: begin
                if (retries_exhausted) begin
                    num_retry_reset = 1'b1;
`ifdef CXL_LRSM_PHY_REINIT_EN
                    if (reinit_cnt_q == MAX_NUM_PHY_REINIT) begin
                        state_d = LRSM_ABORT;
                    end else begin
                        state_d      = LRSM_PHY_REINIT;
                        reinit_cnt_d = reinit_cnt_q + 2'd1;
                    end
`else
                    state_d = LRSM_ABORT;
`endif
                end else if (retryreq_ack) begin
                    num_retry_inc_en = 1'b1;
                    timer_clr        = 1'b1;
                    state_d          = LRSM_LOCAL_IDLE;
                end
            end
            LRSM_LOCAL_IDLE: begin
                // A matching ack beats a timeout landing in the same cycle.
                if (ack_matched) begin
                    state_d                  = LRSM_NORMAL;
                    num_retry_reset          = 1'b1;
                    empty_bit_detected_reset = retryack_empty_bit;
`ifdef CXL_LRSM_PHY_REINIT_EN
                    reinit_cnt_d             = 2'd0;
`endif
                end else if (timer_tc) begin
                    state_d = LRSM_LLRREQ;
                end
            end
`ifdef CXL_LRSM_PHY_REINIT_EN
            LRSM_PHY_REINIT: begin
                if (phy_reinit_done) begin
                    state_d = LRSM_LLRREQ;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= LRSM_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign send_retryreq = (state_q == LRSM_LLRREQ);
    assign rx_discard    = (state_q != LRSM_NORMAL);
    assign link_abort    = (state_q == LRSM_ABORT);
    assign lrsm_state    = state_q;

endmodule

// File: tb/tb_cxl_lrsm_ctrl.sv
// Self-checking bench for cxl_lrsm_ctrl: directed retry scenarios followed by
// random traffic compared against a cycle-indexed behavioural model.
module tb_cxl_lrsm_ctrl;

    localparam logic [4:0]  MAXR = 5'd3;
    localparam logic [11:0] TMO  = 12'd16;
    localparam logic [1:0]  MAXP = 2'd2;
`ifdef CXL_LRSM_PHY_REINIT_EN
    localparam bit PHY_EN = 1'b1;
`else
    localparam bit PHY_EN = 1'b0;
`endif

    localparam int S_NORMAL = 0;
    localparam int S_LLRREQ = 1;
    localparam int S_IDLE   = 2;
    localparam int S_PHY    = 3;
    localparam int S_ABORT  = 4;

    logic       i_clk              = 1'b0;
    logic       i_rst_n            = 1'b0;
    logic       crc_err_detected   = 1'b0;
    logic       retryreq_ack       = 1'b0;
    logic       retryack_rcvd      = 1'b0;
    logic       retryack_empty_bit = 1'b0;
    logic       num_retry_matches  = 1'b0;
    logic [4:0] retry_num_retry    = 5'd0;
    logic       phy_reinit_done    = 1'b0;
    logic       send_retryreq;
    logic       num_retry_inc_en;
    logic       num_retry_reset;
    logic       empty_bit_detected_reset;
    logic       rx_discard;
    logic       phy_reinit_req;
    logic       link_abort;
    logic [2:0] lrsm_state;

    cxl_lrsm_ctrl #(
        .MAX_NUM_RETRY      (MAXR),
        .TIMEOUT_CYC        (TMO),
        .MAX_NUM_PHY_REINIT (MAXP)
    ) dut (
        .i_clk                    (i_clk),
        .i_rst_n                  (i_rst_n),
        .crc_err_detected         (crc_err_detected),
        .retryreq_ack             (retryreq_ack),
        .retryack_rcvd            (retryack_rcvd),
        .retryack_empty_bit       (retryack_empty_bit),
        .num_retry_matches        (num_retry_matches),
        .retry_num_retry          (retry_num_retry),
        .phy_reinit_done          (phy_reinit_done),
        .send_retryreq            (send_retryreq),
        .num_retry_inc_en         (num_retry_inc_en),
        .num_retry_reset          (num_retry_reset),
        .empty_bit_detected_reset (empty_bit_detected_reset),
        .rx_discard               (rx_discard),
        .phy_reinit_req           (phy_reinit_req),
        .link_abort               (link_abort),
        .lrsm_state               (lrsm_state)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Model: state number, PHY reinits since last good ack, the NUM_RETRY
    // counter the bench maintains, a free cycle index and the cycle index at
    // which LOCAL_IDLE was last entered.
    int m_state      = S_NORMAL;
    int m_reinits    = 0;
    int m_nr         = 0;
    int m_cyc        = 0;
    int m_idle_since = 0;
    int dut_prev_st  = 0;
    int dut_phy_ent  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_outs();
        return {send_retryreq, num_retry_inc_en, num_retry_reset, empty_bit_detected_reset,
                rx_discard, phy_reinit_req, link_abort};
    endfunction

    // One clock cycle: called just after a falling edge, returns after the next one.
    task automatic step(input bit crc, input bit rra, input bit ackr, input bit emp,
                        input bit match, input bit prd);
        int         n_state;
        int         n_reinits;
        int         n_nr;
        int         n_idle;
        logic       e_inc;
        logic       e_rst;
        logic       e_emp;
        logic [6:0] e_outs;
        crc_err_detected   = crc;
        retryreq_ack       = rra;
        retryack_rcvd      = ackr;
        retryack_empty_bit = emp;
        num_retry_matches  = match;
        phy_reinit_done    = prd;
        retry_num_retry    = 5'(m_nr);
        #1;
        n_state   = m_state;
        n_reinits = m_reinits;
        n_idle    = m_idle_since;
        e_inc     = 1'b0;
        e_rst     = 1'b0;
        e_emp     = 1'b0;
        if (m_state == S_NORMAL && crc) begin
            n_state = S_LLRREQ;
        end else if (m_state == S_LLRREQ && m_nr >= int'(MAXR)) begin
            e_rst = 1'b1;
            if (PHY_EN && m_reinits < int'(MAXP)) begin
                n_state   = S_PHY;
                n_reinits = m_reinits + 1;
            end else begin
                n_state = S_ABORT;
            end
        end else if (m_state == S_LLRREQ && rra) begin
            e_inc   = 1'b1;
            n_state = S_IDLE;
            n_idle  = m_cyc + 1;
        end else if (m_state == S_IDLE && ackr && match) begin
            n_state   = S_NORMAL;
            e_rst     = 1'b1;
            e_emp     = emp;
            n_reinits = 0;
        end else if (m_state == S_IDLE && (m_cyc - m_idle_since) == int'(TMO) - 1) begin
            n_state = S_LLRREQ;
        end else if (m_state == S_PHY && prd) begin
            n_state = S_LLRREQ;
        end
        n_nr = e_rst ? 0 : (e_inc ? ((m_nr < 31) ? m_nr + 1 : 31) : m_nr);
        e_outs = {m_state == S_LLRREQ, e_inc, e_rst, e_emp,
                  m_state != S_NORMAL, m_state == S_PHY, m_state == S_ABORT};
        check("state", 32'(lrsm_state), 32'(m_state));
        check("outs", 32'(dut_outs()), 32'(e_outs));
        if (int'(lrsm_state) == S_PHY && dut_prev_st != S_PHY) dut_phy_ent++;
        dut_prev_st = int'(lrsm_state);
        @(posedge i_clk);
        m_state      = n_state;
        m_reinits    = n_reinits;
        m_nr         = n_nr;
        m_idle_since = n_idle;
        m_cyc++;
        @(negedge i_clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset between clock edges and checks it takes effect at once.
    task automatic do_reset(input string tag);
        #2;
        i_rst_n = 1'b0;
        #1;
        check({tag, "_state"}, 32'(lrsm_state), 32'(S_NORMAL));
        check({tag, "_outs"}, 32'(dut_outs()), 32'd0);
        crc_err_detected = 0; retryreq_ack = 0; retryack_rcvd = 0;
        retryack_empty_bit = 0; num_retry_matches = 0; phy_reinit_done = 0;
        retry_num_retry = 5'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        m_state   = S_NORMAL;
        m_reinits = 0;
        m_nr      = 0;
        dut_prev_st = 0;
        $display("reset %s done at %0t", tag, $time);
    endtask

    initial begin
        int n;
        int abort_age;
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_init_state", 32'(lrsm_state), 32'(S_NORMAL));
        check("rst_init_outs", 32'(dut_outs()), 32'd0);
        i_rst_n = 1'b1;
        idle_steps(2);

        // Basic retry: crc at cycle 0, packer ack at cycle 3, matching empty ack.
        step(1, 0, 0, 0, 0, 0);
        check("basic_llrreq", 32'(lrsm_state), 32'(S_LLRREQ));
        idle_steps(2);
        step(0, 1, 0, 0, 0, 0);
        check("basic_idle", 32'(lrsm_state), 32'(S_IDLE));
        idle_steps(3);
        step(0, 0, 1, 1, 1, 0);
        check("basic_normal", 32'(lrsm_state), 32'(S_NORMAL));
        $display("txn basic_retry done, nr=%0d", m_nr);

        // Timeout: mismatched ack at idle cycle 8, LLRREQ after 16 idle cycles.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        n = 0;
        while (int'(lrsm_state) == S_IDLE && n < 40) begin
            step(0, 0, n == 8, 1, 0, 0);
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_llrreq", 32'(lrsm_state), 32'(S_LLRREQ));
        $display("txn timeout done after %0d idle cycles", n);

        // Matching ack on the timeout cycle wins.
        step(0, 1, 0, 0, 0, 0);
        idle_steps(int'(TMO) - 1);
        step(0, 0, 1, 0, 1, 0);
        check("ack_wins", 32'(lrsm_state), 32'(S_NORMAL));
        $display("txn ack_vs_timeout done");

        // Reset while in LOCAL_IDLE.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset("rst_idle");

        // Exhaustion: never ack, always complete PHY reinit, until abort.
        dut_phy_ent = 0;
        step(1, 0, 0, 0, 0, 0);
        n = 0;
        while (int'(lrsm_state) != S_ABORT && n < 600) begin
            step(0, 1, 0, 0, 0, 1);
            n++;
        end
        check("abort_reached", 32'(lrsm_state), 32'(S_ABORT));
        check("phy_reinits", 32'(dut_phy_ent), PHY_EN ? 32'(MAXP) : 32'd0);
        for (int i = 0; i < 8; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        check("abort_sticky", 32'(link_abort), 32'd1);
        $display("txn exhaustion done after %0d cycles, reinits=%0d", n, dut_phy_ent);
        do_reset("rst_abort");

        // Random traffic.
        abort_age = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0 || abort_age > 30) begin
                do_reset("rst_rand");
                abort_age = 0;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 4) == 0);
            abort_age = (m_state == S_ABORT) ? abort_age + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cxl_lrsm_ctrl.md
# cxl_lrsm_ctrl

Local Retry State Machine (LRSM) controller for the CXL link-layer retry path. It detects a local CRC error, sequences RETRY.Req transmission and the RETRY.Ack wait, and enforces the timeout. It drives the increment and reset controls of the NUM_RETRY counter and escalates to physical-layer reinit and then link abort when retries are exhausted. It sits between the flit unpacker/CRC checker, the retry-request packer, the NUM_RETRY counter and the PHY interface.

## Interface
Parameters:
- MAX_NUM_RETRY, 5'd5: RETRY.Req attempts allowed before escalation.
- TIMEOUT_CYC, 12'd1000: cycles in LOCAL_IDLE before RETRY.Req is re-sent; legal range 2..4095.
- MAX_NUM_PHY_REINIT, 2'd3: PHY reinit attempts allowed before abort.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; one clock, asynchronous, active-low.
- crc_err_detected  in  1  received flit failed CRC (pulse).
- retryreq_ack  in  1  packer accepted the RETRY.Req in this cycle.
- retryack_rcvd  in  1  unpacker decoded a RETRY.Ack (pulse).
- retryack_empty_bit  in  1  Empty bit of that RETRY.Ack.
- num_retry_matches  in  1  RETRY.Ack NUM_RETRY equals local count minus 1.
- retry_num_retry  in  5  current NUM_RETRY count.
- phy_reinit_done  in  1  PHY completed reinit (pulse).
- send_retryreq  out  1  request packer to send RETRY.Req.
- num_retry_inc_en  out  1  NUM_RETRY increment (pulse).
- num_retry_reset  out  1  NUM_RETRY clear (pulse).
- empty_bit_detected_reset  out  1  clear due to Empty-bit ack (pulse).
- rx_discard  out  1  discard received non-control flits.
- phy_reinit_req  out  1  request PHY reinit.
- link_abort  out  1  retry abort; sticky.
- lrsm_state  out  3  encoded state.

## Operation
States: NORMAL=0, LLRREQ=1, LOCAL_IDLE=2, PHY_REINIT=3, ABORT=4.

- **NORMAL:** crc_err_detected moves to LLRREQ.
- **LLRREQ:**
  - send_retryreq=1 and rx_discard=1.
  - If retry_num_retry >= MAX_NUM_RETRY, move to PHY_REINIT and pulse num_retry_reset. This check has priority over retryreq_ack.
  - Otherwise, on retryreq_ack: pulse num_retry_inc_en, clear the timer, and move to LOCAL_IDLE.
- **LOCAL_IDLE:**
  - rx_discard=1; the timer increments every cycle.
  - retryack_rcvd with num_retry_matches: move to NORMAL, pulse num_retry_reset, pulse empty_bit_detected_reset if retryack_empty_bit=1, and clear the PHY reinit count.
  - retryack_rcvd without a match: ignored.
  - When timer == TIMEOUT_CYC-1: move to LLRREQ.
  - Matching ack and timeout in the same cycle: the ack wins.
  - crc_err_detected is ignored.
- **PHY_REINIT:**
  - phy_reinit_req=1 and rx_discard=1.
  - On entry, the 2-bit reinit count increments.
  - On phy_reinit_done: move to LLRREQ.
- **ABORT:** link_abort=1 and rx_discard=1; exits only on reset.

Escalation from LLRREQ: if the reinit count == MAX_NUM_PHY_REINIT, go to ABORT instead of PHY_REINIT.

## Timing
- State, timer and reinit count are registered.
- send_retryreq, rx_discard, phy_reinit_req, link_abort and lrsm_state are Moore decodes of the registered state.
- Pulse outputs are combinational from state and inputs, last exactly one cycle, and coincide with the transition cycle. NUM_RETRY therefore updates on the same edge as the state change.
- Transition latency: one cycle after the qualifying input.
- Reset values: state NORMAL, timer 0, reinit count 0, all outputs 0.
- Reset asserted mid-operation returns to NORMAL immediately, with no pulses.
- The timer saturates and does not wrap. The reinit count never exceeds MAX_NUM_PHY_REINIT.

## Configuration
- Macro: CXL_LRSM_PHY_REINIT_EN.
- Defined: behaviour as above.
- Undefined:
  - PHY_REINIT and the reinit count are removed.
  - Retry exhaustion in LLRREQ goes directly to ABORT with a num_retry_reset pulse.
  - phy_reinit_req is tied to 0.
  - phy_reinit_done is unused.

## Structure
- Shared package cxl_retry_pkg holds:
  - lrsm_state_e enum (3-bit encoding above);
  - default constants for MAX_NUM_RETRY, TIMEOUT_CYC and MAX_NUM_PHY_REINIT.
- One sub-module, lrsm_timeout_timer: saturating 12-bit counter with clear/enable inputs and a terminal-count output.

## Test plan
- Reset with all inputs 0 -> lrsm_state=0 and every output 0. Reset asserted while in LOCAL_IDLE -> NORMAL immediately.
- Basic retry:
  - crc_err_detected at cycle 0 -> lrsm_state=1 and send_retryreq=1 at cycle 1.
  - retryreq_ack at cycle 3 -> num_retry_inc_en=1 in cycle 3, lrsm_state=2 at cycle 4.
  - retryack_rcvd with match and empty_bit=1 -> num_retry_reset=1 and empty_bit_detected_reset=1 in that cycle, then NORMAL.
- Timeout with TIMEOUT_CYC=16 and no ack -> LLRREQ re-entered exactly 16 cycles after entering LOCAL_IDLE. A mismatched ack at cycle 8 is ignored.
- Same-cycle matching ack and timeout -> NORMAL, not LLRREQ.
- Exhaustion with MAX_NUM_RETRY=3 and retry_num_retry=3 in LLRREQ -> PHY_REINIT next cycle with num_retry_reset pulse. phy_reinit_done -> LLRREQ.
- MAX_NUM_PHY_REINIT=2, after 2 reinits, exhaustion -> ABORT with link_abort=1 held until reset. With the macro undefined, the first exhaustion goes straight to ABORT.
